// File: rtl/sm3_msg_expnd_core_if.sv
// Bus bundle for the SM3 message-expansion stage: the block-word input stream
// and the Wj/W'j output stream that feeds the compression core.
interface sm3_msg_expnd_core_if #(
    parameter int WORD_NUM = 1
);
    localparam int DW = 32 * WORD_NUM;

    logic [DW-1:0] inpt_data_i;
    logic          inpt_vld_i;
    logic          inpt_lst_i;
    logic          inpt_rdy_o;
    logic [DW-1:0] expnd_otpt_wj_o;
    logic [DW-1:0] expnd_otpt_wjj_o;
    logic          expnd_otpt_lst_o;
    logic          expnd_otpt_vld_o;

    // Source side: drives message words, observes ready and the expanded stream.
    modport master (
        output inpt_data_i, inpt_vld_i, inpt_lst_i,
        input  inpt_rdy_o, expnd_otpt_wj_o, expnd_otpt_wjj_o,
        input  expnd_otpt_lst_o, expnd_otpt_vld_o
    );

    // Expansion core side.
    modport slave (
        input  inpt_data_i, inpt_vld_i, inpt_lst_i,
        output inpt_rdy_o, expnd_otpt_wj_o, expnd_otpt_wjj_o,
        output expnd_otpt_lst_o, expnd_otpt_vld_o
    );
endinterface

// File: rtl/sm3_msg_expnd_core.sv
// SM3 message expansion: loads 16 words of a padded block into a sliding
// window, then streams Wj and W'j = Wj ^ Wj+4 for rounds 0..63 with no gaps,
// WORD_NUM rounds per beat. All outputs come straight from registers.
module sm3_msg_expnd_core #(
    parameter int WORD_NUM = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    sm3_msg_expnd_core_if.slave bus
);
    localparam int         DW         = 32 * WORD_NUM;
    localparam logic [5:0] STEP       = 6'(WORD_NUM);
    localparam logic [5:0] LOAD_LAST  = 6'(16 - WORD_NUM);
    localparam logic [5:0] EXPND_LAST = 6'(64 - WORD_NUM);

    typedef enum logic {ST_LOAD, ST_EXPND} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        lst_q, lst_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];

    logic [31:0]   in_word  [WORD_NUM];
    logic [31:0]   new_word [WORD_NUM];
    logic [DW-1:0] wj_vec, wjj_vec;
    logic          load_hs;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    // Per-lane word slicing and next-word computation. Lane gi is round j+gi;
    // every operand comes from the current window, so lanes are independent.
    for (genvar gi = 0; gi < WORD_NUM; gi++) begin : g_lane
        assign in_word[gi]  = bus.inpt_data_i[DW-1-32*gi -: 32];
        assign new_word[gi] = p1(win_q[gi] ^ win_q[gi+7] ^ rotl(win_q[gi+13], 15))
                            ^ rotl(win_q[gi+3], 7) ^ win_q[gi+10];
        assign wj_vec[DW-1-32*gi -: 32]  = win_q[gi];
        assign wjj_vec[DW-1-32*gi -: 32] = win_q[gi] ^ win_q[gi+4];
    end

    assign load_hs = bus.inpt_vld_i && (state_q == ST_LOAD);

    // Next-state logic: window shift (input words or expanded words), counter, lst latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lst_d   = lst_q;
        win_d   = win_q;
        case (state_q)
            ST_LOAD: begin
                if (load_hs) begin
                    for (int i = 0; i < 16 - WORD_NUM; i++) win_d[i] = win_q[i+WORD_NUM];
                    for (int k = 0; k < WORD_NUM; k++) win_d[16-WORD_NUM+k] = in_word[k];
                    if (cnt_q == LOAD_LAST) begin
                        cnt_d   = '0;
                        lst_d   = bus.inpt_lst_i;
                        state_d = ST_EXPND;
                    end else begin
                        cnt_d = cnt_q + STEP;
                    end
                end
            end
            ST_EXPND: begin
                for (int i = 0; i < 16 - WORD_NUM; i++) win_d[i] = win_q[i+WORD_NUM];
                for (int k = 0; k < WORD_NUM; k++) win_d[16-WORD_NUM+k] = new_word[k];
                if (cnt_q == EXPND_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + STEP;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // State registers; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            lst_q   <= 1'b0;
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lst_q   <= lst_d;
            win_q   <= win_d;
        end
    end

    assign bus.inpt_rdy_o       = (state_q == ST_LOAD);
    assign bus.expnd_otpt_vld_o = (state_q == ST_EXPND);
    assign bus.expnd_otpt_lst_o = (state_q == ST_EXPND) && lst_q && (cnt_q == EXPND_LAST);
    assign bus.expnd_otpt_wj_o  = wj_vec;
    assign bus.expnd_otpt_wjj_o = wjj_vec;
endmodule

// File: tb/tb_sm3_msg_expnd_core.sv
// Bench for sm3_msg_expnd_core: one instance per word mode, a reference
// expansion pushed to per-instance queues, a negedge monitor that pops and
// compares, and an SM3 compression of the captured stream for the digest.
module tb_sm3_msg_expnd_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sm3_msg_expnd_core_if #(.WORD_NUM(1)) if1 ();
    sm3_msg_expnd_core_if #(.WORD_NUM(2)) if2 ();

    sm3_msg_expnd_core #(.WORD_NUM(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    sm3_msg_expnd_core #(.WORD_NUM(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    typedef struct {
        logic [63:0] wj;
        logic [63:0] wjj;
        logic        lst;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int total = 0;
    int bad   = 0;
    int beats1 = 0, beats2 = 0, lst1 = 0, lst2 = 0;
    logic [31:0] cap1_wj  [1024];
    logic [31:0] cap1_wjj [1024];
    logic [63:0] cap2_wj  [1024];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 9) ^ rotl(x, 17);
    endfunction

    // Reference expansion in array form, queued as the expected beat stream.
    task automatic push_block(input bit sel, input logic [31:0] m [16], input bit l);
        logic [31:0] w [68];
        exp_t e;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 68; i++)
            w[i] = p1(w[i-16] ^ w[i-9] ^ rotl(w[i-3], 15)) ^ rotl(w[i-13], 7) ^ w[i-6];
        if (!sel) begin
            for (int j = 0; j < 64; j++) begin
                e.wj  = {32'h0, w[j]};
                e.wjj = {32'h0, w[j] ^ w[j+4]};
                e.lst = l && (j == 63);
                q1.push_back(e);
            end
        end else begin
            for (int k = 0; k < 32; k++) begin
                e.wj  = {w[2*k], w[2*k+1]};
                e.wjj = {w[2*k] ^ w[2*k+4], w[2*k+1] ^ w[2*k+5]};
                e.lst = l && (k == 31);
                q2.push_back(e);
            end
        end
    endtask

    // SM3 compression of one block's captured Wj/W'j, from the standard IV.
    function automatic logic [255:0] sm3_digest(input int base);
        logic [31:0] iv [8] = '{32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
                                32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e};
        logic [31:0] a, b, c, d, e, f, g, h, t, ss1, ss2, tt1, tt2, ffv, ggv;
        {a, b, c, d, e, f, g, h} = {iv[0], iv[1], iv[2], iv[3], iv[4], iv[5], iv[6], iv[7]};
        for (int j = 0; j < 64; j++) begin
            t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = rotl(rotl(a, 12) + e + rotl(t, j % 32), 7);
            ss2 = ss1 ^ rotl(a, 12);
            ffv = (j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
            ggv = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
            tt1 = ffv + d + ss2 + cap1_wjj[base+j];
            tt2 = ggv + h + ss1 + cap1_wj[base+j];
            d = c; c = rotl(b, 9); b = a; a = tt1;
            h = g; g = rotl(f, 19); f = e; e = p0(tt2);
        end
        return {a ^ iv[0], b ^ iv[1], c ^ iv[2], d ^ iv[3],
                e ^ iv[4], f ^ iv[5], g ^ iv[6], h ^ iv[7]};
    endfunction

    // Monitor for the 1-word instance: pop and compare every valid beat.
    always @(negedge clk) begin
        exp_t e;
        if (if1.expnd_otpt_vld_o) begin
            if (q1.size() == 0) check_eq("beat1_unexpected", 64'd1, 64'd0);
            else begin
                e = q1.pop_front();
                check_eq("wj1",  {32'h0, if1.expnd_otpt_wj_o},  e.wj);
                check_eq("wjj1", {32'h0, if1.expnd_otpt_wjj_o}, e.wjj);
                check_eq("lst1", {63'h0, if1.expnd_otpt_lst_o}, {63'h0, e.lst});
            end
            if (beats1 < 1024) begin
                cap1_wj[beats1]  <= if1.expnd_otpt_wj_o;
                cap1_wjj[beats1] <= if1.expnd_otpt_wjj_o;
            end
            if (if1.expnd_otpt_lst_o) lst1 <= lst1 + 1;
            beats1 <= beats1 + 1;
        end else if (if1.expnd_otpt_lst_o) begin
            check_eq("lst1_idle", 64'd1, 64'd0);
        end
    end

    // Monitor for the 2-word instance.
    always @(negedge clk) begin
        exp_t e;
        if (if2.expnd_otpt_vld_o) begin
            if (q2.size() == 0) check_eq("beat2_unexpected", 64'd1, 64'd0);
            else begin
                e = q2.pop_front();
                check_eq("wj2",  if2.expnd_otpt_wj_o,  e.wj);
                check_eq("wjj2", if2.expnd_otpt_wjj_o, e.wjj);
                check_eq("lst2", {63'h0, if2.expnd_otpt_lst_o}, {63'h0, e.lst});
            end
            if (beats2 < 1024) cap2_wj[beats2] <= if2.expnd_otpt_wj_o;
            if (if2.expnd_otpt_lst_o) lst2 <= lst2 + 1;
            beats2 <= beats2 + 1;
        end else if (if2.expnd_otpt_lst_o) begin
            check_eq("lst2_idle", 64'd1, 64'd0);
        end
    end

    task automatic set_in(input bit sel, input logic v, input logic [63:0] d, input logic l);
        if (!sel) begin
            if1.inpt_vld_i = v; if1.inpt_data_i = d[31:0]; if1.inpt_lst_i = l;
        end else begin
            if2.inpt_vld_i = v; if2.inpt_data_i = d; if2.inpt_lst_i = l;
        end
    endtask

    // Present one beat after optional idle cycles; while rdy is low either idle
    // or (junk) keep vld high with garbage data that must be ignored.
    task automatic drive_word(input bit sel, input logic [63:0] d, input logic l,
                              input int gaps, input bit junk);
        int guard = 0;
        repeat (gaps) begin
            @(negedge clk);
            set_in(sel, 1'b0, {$urandom, $urandom}, 1'($urandom));
        end
        @(negedge clk);
        while (!(sel ? if2.inpt_rdy_o : if1.inpt_rdy_o)) begin
            set_in(sel, junk, {$urandom, $urandom}, 1'($urandom));
            guard++;
            if (guard > 200) begin
                check_eq("rdy_timeout", 64'd0, 64'd1);
                break;
            end
            @(negedge clk);
        end
        set_in(sel, 1'b1, d, l);
        @(posedge clk);
    endtask

    task automatic send_block(input bit sel, input logic [31:0] m [16], input bit l,
                              input int gap_max, input bit junk);
        int step = sel ? 2 : 1;
        push_block(sel, m, l);
        for (int i = 0; i < 16; i += step) begin
            logic [63:0] d = sel ? {m[i], m[i+1]} : {32'h0, m[i]};
            logic        lb = (i + step == 16) ? l : 1'($urandom);
            drive_word(sel, d, lb, (gap_max > 0) ? $urandom_range(gap_max, 0) : 0, junk);
        end
        @(negedge clk);
        set_in(sel, junk, {$urandom, $urandom}, 1'($urandom));
    endtask

    task automatic wait_drain(input bit sel);
        int n = 0;
        while (((sel ? q2.size() : q1.size()) != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check_eq("drain_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic measure_busy(input string tag);
        int n = 0;
        while (!if1.inpt_rdy_o && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq(tag, 64'(n), 64'd64);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] abc [16];
        logic [31:0] blk_a [16];
        logic [31:0] blk_b [16];
        int b1, b2, l1;
        logic [255:0] dig_exp;
        dig_exp = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
        for (int i = 0; i < 16; i++) abc[i] = 32'h0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;
        for (int i = 0; i < 16; i++) begin
            blk_a[i] = $urandom;
            blk_b[i] = $urandom;
        end
        set_in(1'b0, 1'b0, 64'h0, 1'b0);
        set_in(1'b1, 1'b0, 64'h0, 1'b0);

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rdy1", {63'h0, if1.inpt_rdy_o}, 64'd1);
        check_eq("rst_vld1", {63'h0, if1.expnd_otpt_vld_o}, 64'd0);
        check_eq("rst_lst1", {63'h0, if1.expnd_otpt_lst_o}, 64'd0);
        check_eq("rst_wj1",  {32'h0, if1.expnd_otpt_wj_o}, 64'd0);
        check_eq("rst_wjj1", {32'h0, if1.expnd_otpt_wjj_o}, 64'd0);
        check_eq("rst_rdy2", {63'h0, if2.inpt_rdy_o}, 64'd1);
        check_eq("rst_wj2",  if2.expnd_otpt_wj_o, 64'd0);
        rst_n = 1'b1;

        // "abc" block, 1-word mode, plus digest through a reference compressor.
        b1 = beats1; l1 = lst1;
        send_block(1'b0, abc, 1'b1, 0, 1'b0);
        wait_drain(1'b0);
        check_eq("abc_beats", 64'(beats1 - b1), 64'd64);
        check_eq("abc_lst_cnt", 64'(lst1 - l1), 64'd1);
        check_eq("abc_w16", {32'h0, cap1_wj[b1+16]}, 64'h9092e200);
        check_eq("abc_w17", {32'h0, cap1_wj[b1+17]}, 64'h00000000);
        check_eq("abc_w18", {32'h0, cap1_wj[b1+18]}, 64'h000c0606);
        check_eq("abc_w19", {32'h0, cap1_wj[b1+19]}, 64'h719c70ed);
        check_eq("abc_wjj0", {32'h0, cap1_wjj[b1]}, 64'h61626380);
        check_eq("abc_dig_hi", 64'(sm3_digest(b1) >> 192), dig_exp[255:192]);
        check_eq("abc_dig_lo", sm3_digest(b1)[63:0], dig_exp[63:0]);

        // "abc" block, 2-word mode.
        b2 = beats2;
        send_block(1'b1, abc, 1'b1, 0, 1'b0);
        wait_drain(1'b1);
        check_eq("w2_beats", 64'(beats2 - b2), 64'd32);
        check_eq("w2_beat8", cap2_wj[b2+8], {32'h9092e200, 32'h00000000});

        // Two blocks with random idle gaps during load; lst 0 then 1.
        b1 = beats1; l1 = lst1;
        send_block(1'b0, blk_a, 1'b0, 3, 1'b0);
        measure_busy("busy_blk_a");
        send_block(1'b0, blk_b, 1'b1, 3, 1'b0);
        measure_busy("busy_blk_b");
        wait_drain(1'b0);
        check_eq("gap_beats", 64'(beats1 - b1), 64'd128);
        check_eq("gap_lst_cnt", 64'(lst1 - l1), 64'd1);

        // Reset pulse while round 30 is on the output.
        b1 = beats1; l1 = lst1;
        send_block(1'b0, abc, 1'b1, 0, 1'b0);
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_vld", {63'h0, if1.expnd_otpt_vld_o}, 64'd0);
        check_eq("mid_rst_rdy", {63'h0, if1.inpt_rdy_o}, 64'd1);
        q1.delete();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("mid_rst_beats", 64'(beats1 - b1), 64'd31);
        check_eq("mid_rst_lst", 64'(lst1 - l1), 64'd0);
        b1 = beats1; l1 = lst1;
        send_block(1'b0, abc, 1'b1, 0, 1'b0);
        wait_drain(1'b0);
        check_eq("rerun_beats", 64'(beats1 - b1), 64'd64);
        check_eq("rerun_lst", 64'(lst1 - l1), 64'd1);
        check_eq("rerun_dig_hi", 64'(sm3_digest(b1) >> 192), dig_exp[255:192]);

        // vld held high with changing data during expansion.
        b1 = beats1; l1 = lst1;
        send_block(1'b0, blk_a, 1'b0, 0, 1'b1);
        send_block(1'b0, abc, 1'b1, 0, 1'b1);
        @(negedge clk);
        set_in(1'b0, 1'b0, 64'h0, 1'b0);
        wait_drain(1'b0);
        check_eq("junk_beats", 64'(beats1 - b1), 64'd128);
        check_eq("junk_lst", 64'(lst1 - l1), 64'd1);
        check_eq("junk_dig_lo", sm3_digest(b1 + 64)[63:0], dig_exp[63:0]);
        check_eq("q_left", 64'(q1.size() + q2.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
